pdu_tx_framer: RTL and testbench
================================

# pdu_tx_framer

Transmit-side counterpart of the RX PDU generator. Consumes byte-swapped 512-bit flits drained from the PCIe TX packet buffer, plus one transmit descriptor per packet giving its length in bytes. Emits an Ethernet-side Avalon-ST stream (sop/eop/empty) toward the MAC/TX pipeline. Sits between the PCIe TX DMA buffers and the network egress path.

## Interface
- MAX_PKT_BYTES, 9600: descriptors with size above this are dropped.
- MIN_FRAME_BYTES, 60: runt padding target; used only with TX_PAD_RUNT_EN.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- in_pkt_data  in  512  flit from the PCIe TX buffer, PCIe byte order.
- in_pkt_valid  in  1  flit valid.
- in_pkt_ready  out  1  flit accepted when valid & ready.
- in_desc_data  in  tx_desc_t  descriptor: size[15:0] in bytes.
- in_desc_valid  in  1  descriptor valid.
- in_desc_ready  out  1  descriptor accepted when valid & ready.
- out_data  out  512  Ethernet-order data; first byte in [511:504].
- out_sop, out_eop  out  1  packet boundaries.
- out_empty  out  6  unused bytes in the eop flit; 0 on other flits.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- tx_pkt_cnt  out  32  count of packets emitted with eop.
- tx_drop_cnt  out  32  count of descriptors dropped (size 0 or oversize).

## Operation
- State machine: IDLE, STREAM, DRAIN.
- IDLE
  - in_desc_ready = 1 when skid not full.
  - size == 0: consume the descriptor and no flits; tx_drop_cnt++; stay in IDLE.
  - size > MAX_PKT_BYTES: consume the descriptor; flits_left = ceil(size/64); tx_drop_cnt++; go to DRAIN.
  - Otherwise: flits_left = ceil(size/64); latch size[5:0].
    - A flit may be accepted in the same cycle as the descriptor (in_pkt_ready = in_desc_valid & in_desc_ready & !skid_full). That flit gets out_sop = 1.
    - If no flit is accepted that cycle, the first flit accepted in STREAM gets sop.
- STREAM
  - in_pkt_ready = !skid_full; in_desc_ready = 0.
  - Each accepted flit: flits_left--.
  - Flit with flits_left == 1 gets out_eop = 1 and out_empty = (64 - size[5:0]) mod 64; tx_pkt_cnt++. Then go to IDLE.
- DRAIN
  - in_pkt_ready = 1, independent of output backpressure.
  - Consumes flits_left flits with no output, then goes to IDLE.
- Data path: out_data = swap_flit_endianness(in_pkt_data).
- Arithmetic: flits_left is 10 bits. ceil = size[15:6] + |size[5:0]. Counters wrap modulo 2^32.
- The PCIe side places each packet starting on a flit boundary. Trailing bytes of the eop flit are passed through unmodified, except under padding.

## Timing
- Accepted flits enter a 2-entry skid buffer with a registered output.
- Latency from input accept to out_valid: 1 cycle.
- Full throughput: one flit per cycle with no bubble between packets when a descriptor and its first flit arrive together.
- out_valid, once high, holds with stable data until out_ready.
- Reset values: state IDLE, skid empty.
  - out_valid, out_sop, out_eop = 0; out_empty = 0.
  - tx_pkt_cnt, tx_drop_cnt = 0; in_pkt_ready, in_desc_ready = 0 during rst.
- Reset mid-packet discards the partial packet and skid contents. No eop is emitted for it.

## Configuration
- TX_PAD_RUNT_EN defined:
  - Descriptors with 0 < size < MIN_FRAME_BYTES are emitted as a single flit with out_empty = 64 - MIN_FRAME_BYTES (4).
  - Bytes from position size through 59 are forced to zero.
  - Only one input flit is consumed.
- TX_PAD_RUNT_EN undefined: runts are emitted at their true length; no zeroing logic is instantiated.

## Structure
- tx_desc_t, plus the MAX/MIN frame constants, go in the shared constants package alongside metadata_t/pkt_meta_t.
- swap_flit_endianness is reused from the package.
- One sub-module: flit_skid_buf, a 2-entry registered skid buffer carrying {data, sop, eop, empty}. It provides a full flag.

## Test plan
- Descriptor size 64 with 1 flit, presented together: one flit out with sop = eop = 1, empty = 0, one cycle later; tx_pkt_cnt = 1.
- Size 130 with 3 flits back-to-back, followed immediately by size 65: 5 output flits on consecutive cycles; empties 62 and 63; sop on flits 1 and 4.
- Size 0, then size 10000 with 157 flits, then size 100: the first two are dropped (tx_drop_cnt = 2), 157 flits are drained, and the size-100 packet is emitted with empty 28.
- out_ready toggling 50% during a 20-flit packet: no flit lost or duplicated; data stable while stalled.
- TX_PAD_RUNT_EN, size 42: empty = 4; bytes 42–59 read zero. Without the macro: empty = 22 and the bytes are unchanged.
- rst asserted after flit 2 of a 5-flit packet: all outputs reset next cycle; the next packet is emitted with correct sop and count.

Source files
------------

// File: rtl/pdu_tx_framer_pkg.sv
// ============================================================================
// Module   : pdu_tx_framer_pkg
// Brief    : Shared TX-path constants, descriptor/metadata types and flit helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pdu_tx_framer_pkg;

    localparam int FLIT_BYTES         = 64;
    localparam int TX_MAX_PKT_BYTES   = 9600;
    localparam int TX_MIN_FRAME_BYTES = 60;

    typedef struct packed {
        logic [15:0] size;
    } tx_desc_t;

    typedef struct packed {
        logic [15:0] len;
        logic [7:0]  port;
        logic [7:0]  flags;
    } metadata_t;

    typedef struct packed {
        metadata_t   meta;
        logic [31:0] timestamp;
    } pkt_meta_t;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } flit_t;

    // PCIe byte 0 sits in [7:0]; Ethernet byte 0 must land in [511:504].
    function automatic logic [511:0] swap_flit_endianness(input logic [511:0] flit);
        logic [511:0] swapped;
        swapped = '0;
        for (int i = 0; i < FLIT_BYTES; i++) begin
            swapped[511-8*i -: 8] = flit[8*i +: 8];
        end
        return swapped;
    endfunction

    function automatic logic [9:0] ceil_flits(input logic [15:0] size);
        return size[15:6] + {9'd0, |size[5:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pdu_tx_framer_skid_buf.sv
// ============================================================================
// Module   : flit_skid_buf
// Brief    : Two-entry skid buffer with registered output carrying flit_t.
// Revision : 1.0
// ============================================================================
`default_nettype none

module flit_skid_buf
    import pdu_tx_framer_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    input  flit_t in_flit,
    output logic  full,
    output logic  out_valid,
    output flit_t out_flit,
    input  logic  out_ready
);

    logic  out_vld_q, out_vld_d;
    flit_t out_q, out_d;
    logic  sk_vld_q, sk_vld_d;
    flit_t sk_q, sk_d;
    logic  pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
            sk_vld_q  <= 1'b0;
            sk_q      <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            sk_vld_q  <= sk_vld_d;
            sk_q      <= sk_d;
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_d     = out_q;
        sk_vld_d  = sk_vld_q;
        sk_d      = sk_q;
        pop       = out_vld_q & out_ready;
        if (!out_vld_q || pop) begin
            // Output slot frees up: the older skid entry always goes first.
            if (sk_vld_q) begin
                out_vld_d = 1'b1;
                out_d     = sk_q;
                sk_vld_d  = in_valid;
                if (in_valid) begin
                    sk_d = in_flit;
                end
            end else begin
                out_vld_d = in_valid;
                if (in_valid) begin
                    out_d = in_flit;
                end
            end
        end else if (in_valid) begin
            sk_vld_d = 1'b1;
            sk_d     = in_flit;
        end
    end

    assign full      = sk_vld_q;
    assign out_valid = out_vld_q;
    assign out_flit  = out_q;

endmodule

`default_nettype wire

// File: rtl/pdu_tx_framer.sv
// ============================================================================
// Module   : pdu_tx_framer
// Brief    : Frames byte-swapped PCIe TX flits into an Avalon-ST egress stream.
//            Optional runt padding is enabled by defining TX_PAD_RUNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pdu_tx_framer
    import pdu_tx_framer_pkg::*;
#(
    parameter int MAX_PKT_BYTES = TX_MAX_PKT_BYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] in_pkt_data,
    input  logic         in_pkt_valid,
    output logic         in_pkt_ready,
    input  tx_desc_t     in_desc_data,
    input  logic         in_desc_valid,
    output logic         in_desc_ready,
    output logic [511:0] out_data,
    output logic         out_sop,
    output logic         out_eop,
    output logic [5:0]   out_empty,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  tx_pkt_cnt,
    output logic [31:0]  tx_drop_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [9:0]  flits_left_q, flits_left_d;
    logic [5:0]  size_lo_q, size_lo_d;
    logic        sop_pend_q, sop_pend_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
`ifdef TX_PAD_RUNT_EN
    logic        pad_q, pad_d;
    logic        cur_pad;
`endif

    logic [15:0] desc_size;
    logic [9:0]  desc_flits;
    logic        desc_zero;
    logic        desc_over;
    logic        desc_acc;
    logic        pkt_acc;
    logic        push;
    logic [9:0]  cur_flits;
    logic [5:0]  cur_size_lo;
    logic        skid_full;
    flit_t       push_flit;
    flit_t       skid_out;

    assign desc_size  = in_desc_data.size;
    assign desc_flits = ceil_flits(desc_size);
    assign desc_zero  = (desc_size == 16'd0);
    assign desc_over  = ({16'd0, desc_size} > 32'(MAX_PKT_BYTES));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            flits_left_q <= '0;
            size_lo_q    <= '0;
            sop_pend_q   <= 1'b0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
`ifdef TX_PAD_RUNT_EN
            pad_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            flits_left_q <= flits_left_d;
            size_lo_q    <= size_lo_d;
            sop_pend_q   <= sop_pend_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef TX_PAD_RUNT_EN
            pad_q        <= pad_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        flits_left_d = flits_left_q;
        size_lo_d    = size_lo_q;
        sop_pend_d   = sop_pend_q;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
`ifdef TX_PAD_RUNT_EN
        pad_d        = pad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (desc_acc) begin
                    if (desc_zero) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end else if (desc_over) begin
                        drop_cnt_d   = drop_cnt_q + 32'd1;
                        flits_left_d = desc_flits;
                        state_d      = ST_DRAIN;
                    end else begin
                        size_lo_d = desc_size[5:0];
`ifdef TX_PAD_RUNT_EN
                        pad_d     = ({16'd0, desc_size} < 32'(TX_MIN_FRAME_BYTES));
`endif
                        if (pkt_acc) begin
                            flits_left_d = desc_flits - 10'd1;
                            sop_pend_d   = 1'b0;
                            if (desc_flits == 10'd1) begin
                                pkt_cnt_d = pkt_cnt_q + 32'd1;
                            end else begin
                                state_d = ST_STREAM;
                            end
                        end else begin
                            flits_left_d = desc_flits;
                            sop_pend_d   = 1'b1;
                            state_d      = ST_STREAM;
                        end
                    end
                end
            end
            ST_STREAM: begin
                if (pkt_acc) begin
                    flits_left_d = flits_left_q - 10'd1;
                    sop_pend_d   = 1'b0;
                    if (flits_left_q == 10'd1) begin
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (pkt_acc) begin
                    flits_left_d = flits_left_q - 10'd1;
                    if (flits_left_q == 10'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: handshakes and the flit pushed into the skid buffer
    always_comb begin
        in_desc_ready = !rst && (state_q == ST_IDLE) && !skid_full;
        in_pkt_ready  = 1'b0;
        case (state_q)
            ST_IDLE:   in_pkt_ready = !rst && in_desc_valid && !skid_full && !desc_zero && !desc_over;
            ST_STREAM: in_pkt_ready = !rst && !skid_full;
            ST_DRAIN:  in_pkt_ready = !rst;
            default:   in_pkt_ready = 1'b0;
        endcase
        desc_acc    = in_desc_valid && in_desc_ready;
        pkt_acc     = in_pkt_valid && in_pkt_ready;
        push        = pkt_acc && (state_q != ST_DRAIN);
        cur_flits   = (state_q == ST_IDLE) ? desc_flits : flits_left_q;
        cur_size_lo = (state_q == ST_IDLE) ? desc_size[5:0] : size_lo_q;

        push_flit.data  = swap_flit_endianness(in_pkt_data);
        push_flit.sop   = (state_q == ST_IDLE) || sop_pend_q;
        push_flit.eop   = (cur_flits == 10'd1);
        push_flit.empty = push_flit.eop ? (6'd0 - cur_size_lo) : 6'd0;
`ifdef TX_PAD_RUNT_EN
        cur_pad = (state_q == ST_IDLE) ? ({16'd0, desc_size} < 32'(TX_MIN_FRAME_BYTES)) : pad_q;
        if (cur_pad) begin
            push_flit.empty = 6'(FLIT_BYTES - TX_MIN_FRAME_BYTES);
            for (int p = 0; p < FLIT_BYTES; p++) begin
                if (p >= int'(cur_size_lo) && p < TX_MIN_FRAME_BYTES) begin
                    push_flit.data[511-8*p -: 8] = 8'd0;
                end
            end
        end
`endif
    end

    flit_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_flit   (push_flit),
        .full      (skid_full),
        .out_valid (out_valid),
        .out_flit  (skid_out),
        .out_ready (out_ready)
    );

    assign out_data    = skid_out.data;
    assign out_sop     = skid_out.sop;
    assign out_eop     = skid_out.eop;
    assign out_empty   = skid_out.empty;
    assign tx_pkt_cnt  = pkt_cnt_q;
    assign tx_drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pdu_tx_framer.sv
// ============================================================================
// Module   : tb_pdu_tx_framer
// Brief    : Directed self-checking bench for pdu_tx_framer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pdu_tx_framer;
    import pdu_tx_framer_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] in_pkt_data = '0;
    logic         in_pkt_valid = 1'b0;
    logic         in_pkt_ready;
    tx_desc_t     in_desc_data = '0;
    logic         in_desc_valid = 1'b0;
    logic         in_desc_ready;
    logic [511:0] out_data;
    logic         out_sop;
    logic         out_eop;
    logic [5:0]   out_empty;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  tx_pkt_cnt;
    logic [31:0]  tx_drop_cnt;

    typedef struct {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } exp_t;

    exp_t         exp_q[$];
    int           out_cyc[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    logic         stalled = 1'b0;
    logic [511:0] held = '0;
    logic         bp_on = 1'b0;

    always #5 clk = ~clk;

    pdu_tx_framer dut (
        .clk           (clk),
        .rst           (rst),
        .in_pkt_data   (in_pkt_data),
        .in_pkt_valid  (in_pkt_valid),
        .in_pkt_ready  (in_pkt_ready),
        .in_desc_data  (in_desc_data),
        .in_desc_valid (in_desc_valid),
        .in_desc_ready (in_desc_ready),
        .out_data      (out_data),
        .out_sop       (out_sop),
        .out_eop       (out_eop),
        .out_empty     (out_empty),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .tx_pkt_cnt    (tx_pkt_cnt),
        .tx_drop_cnt   (tx_drop_cnt)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // PCIe-order flit: byte i in [8i+7:8i] holds tag+i.
    function automatic logic [511:0] mk_pcie(input int tag);
        logic [511:0] f;
        for (int i = 0; i < 64; i++) f[8*i +: 8] = 8'(tag + i);
        return f;
    endfunction

    // Ethernet-order flit: byte p in [511-8p -: 8] holds tag+p.
    function automatic logic [511:0] mk_eth(input int tag);
        logic [511:0] f;
        for (int p = 0; p < 64; p++) f[511-8*p -: 8] = 8'(tag + p);
        return f;
    endfunction

    task automatic push_exp(input logic [511:0] d, input logic s, input logic e, input logic [5:0] em);
        exp_t x;
        x.data = d; x.sop = s; x.eop = e; x.empty = em;
        exp_q.push_back(x);
    endtask

    task automatic tx_pkt(input int size, input int nflits, input int base,
                          input logic [5:0] exp_empty, input logic emit);
        int   sent = 0;
        int   budget = 0;
        logic desc_done = 1'b0;
        logic d_acc, p_acc;
        if (emit) begin
            for (int j = 0; j < nflits; j++)
                push_exp(mk_eth(base + j), j == 0, j == nflits - 1,
                         (j == nflits - 1) ? exp_empty : 6'd0);
        end
        in_desc_data.size = 16'(size);
        while (!desc_done || sent < nflits) begin
            in_desc_valid = !desc_done;
            in_pkt_valid  = (sent < nflits);
            in_pkt_data   = mk_pcie(base + sent);
            @(negedge clk);
            d_acc = in_desc_valid && in_desc_ready;
            p_acc = in_pkt_valid && in_pkt_ready;
            @(posedge clk);
            #1;
            if (d_acc) desc_done = 1'b1;
            if (p_acc) sent++;
            budget++;
            if (budget > 2000) begin
                check_eq("tx_timeout", 1, 0);
                break;
            end
        end
        in_desc_valid = 1'b0;
        in_pkt_valid  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_remaining", exp_q.size(), 0);
    endtask

    // Output monitor and scoreboard; the handshake completes at the next rising edge.
    always @(negedge clk) begin
        exp_t x;
        cyc++;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_flit", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    check_eq("out_data", out_data, x.data);
                    check_eq("out_sop", out_sop, x.sop);
                    check_eq("out_eop", out_eop, x.eop);
                    check_eq("out_empty", out_empty, x.empty);
                end
                out_cyc.push_back(cyc);
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
        end
    end

    initial begin
        logic [511:0] pad_exp;
        logic [5:0]   pad_empty;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pkt_ready", in_pkt_ready, 0);
        check_eq("rst_desc_ready", in_desc_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_sop", out_sop, 0);
        check_eq("rst_out_eop", out_eop, 0);
        check_eq("rst_out_empty", out_empty, 0);
        check_eq("rst_pkt_cnt", tx_pkt_cnt, 0);
        check_eq("rst_drop_cnt", tx_drop_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single 64-byte flit, descriptor and flit together; visible one cycle later
        tx_pkt(64, 1, 8'h00, 6'd0, 1'b1);
        check_eq("t1_latency_valid", out_valid, 1);
        check_eq("t1_sop", out_sop, 1);
        check_eq("t1_eop", out_eop, 1);
        check_eq("t1_pkt_cnt", tx_pkt_cnt, 1);
        wait_drain();

        // 130 bytes (3 flits) then 65 bytes (2 flits) back-to-back
        out_cyc.delete();
        tx_pkt(130, 3, 8'h20, 6'd62, 1'b1);
        tx_pkt(65, 2, 8'h40, 6'd63, 1'b1);
        wait_drain();
        check_eq("t2_out_count", out_cyc.size(), 5);
        if (out_cyc.size() == 5)
            check_eq("t2_no_bubble", out_cyc[4] - out_cyc[0], 4);
        check_eq("t2_pkt_cnt", tx_pkt_cnt, 3);

        // Zero-size drop, oversize drop with 157-flit drain, then a 100-byte packet
        tx_pkt(0, 0, 8'h70, 6'd0, 1'b0);
        tx_pkt(10000, 157, 8'h80, 6'd0, 1'b0);
        tx_pkt(100, 2, 8'h90, 6'd28, 1'b1);
        wait_drain();
        check_eq("t3_drop_cnt", tx_drop_cnt, 2);
        check_eq("t3_pkt_cnt", tx_pkt_cnt, 4);

        // 20-flit packet with out_ready toggling every cycle
        bp_on = 1'b1;
        fork
            begin
                tx_pkt(1280, 20, 8'hA0, 6'd0, 1'b1);
                bp_on = 1'b0;
            end
            begin
                while (bp_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        check_eq("t4_pkt_cnt", tx_pkt_cnt, 5);

        // 42-byte runt
        pad_exp = mk_eth(8'hC0);
`ifdef TX_PAD_RUNT_EN
        for (int p = 42; p < 60; p++) pad_exp[511-8*p -: 8] = 8'd0;
        pad_empty = 6'd4;
`else
        pad_empty = 6'd22;
`endif
        push_exp(pad_exp, 1'b1, 1'b1, pad_empty);
        in_desc_data.size = 16'd42;
        tx_pkt(42, 1, 8'hC0, pad_empty, 1'b0);
        wait_drain();
        check_eq("t5_pkt_cnt", tx_pkt_cnt, 6);

        // Reset after the second flit of a 5-flit packet
        push_exp(mk_eth(8'h50), 1'b1, 1'b0, 6'd0);
        in_desc_data.size = 16'd320;
        in_desc_valid = 1'b1;
        in_pkt_valid  = 1'b1;
        in_pkt_data   = mk_pcie(8'h50);
        @(posedge clk);
        #1;
        in_desc_valid = 1'b0;
        in_pkt_data   = mk_pcie(8'h51);
        @(posedge clk);
        #1;
        in_pkt_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_pkt_ready", in_pkt_ready, 0);
        check_eq("t6_rst_desc_ready", in_desc_ready, 0);
        @(posedge clk);
        #1;
        check_eq("t6_out_valid", out_valid, 0);
        check_eq("t6_out_sop", out_sop, 0);
        check_eq("t6_out_eop", out_eop, 0);
        check_eq("t6_pkt_cnt", tx_pkt_cnt, 0);
        check_eq("t6_drop_cnt", tx_drop_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t6_partial_seen", exp_q.size(), 0);
        exp_q.delete();
        tx_pkt(128, 2, 8'h60, 6'd0, 1'b1);
        wait_drain();
        check_eq("t6_after_pkt_cnt", tx_pkt_cnt, 1);

        repeat (3) @(posedge clk);
        #1;
        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
